// File: rtl/servo_pwm_gen_if.sv
// Interface between the PID controller side and the servo PWM stage:
// the duty request strobe and enable go in, the PWM waveform and status come out.
interface servo_pwm_gen_if;
   logic        en;
   logic [17:0] duty_in;
   logic        duty_valid;
   logic        pwm_out;
   logic        period_tick;
   logic [17:0] duty_active;
   logic        duty_clamped;

   modport master (
      output en, duty_in, duty_valid,
      input  pwm_out, period_tick, duty_active, duty_clamped
   );

   modport slave (
      input  en, duty_in, duty_valid,
      output pwm_out, period_tick, duty_active, duty_clamped
   );
endinterface

// File: rtl/servo_pwm_gen.sv
// Fixed-period servo PWM generator with clamped, double-buffered duty.
// Pulse width is only updated at period boundaries so the servo never sees a glitch.
module servo_pwm_gen #(
   parameter int PERIOD_CNT  = 1000000,
   parameter int MIN_DUTY    = 50000,
   parameter int CENTER_DUTY = 75000,
   parameter int MAX_DUTY    = 100000,
   parameter int CNT_W       = 20
) (
   input  logic           clk,
   input  logic           rst_n,
   servo_pwm_gen_if.slave bus
);

   localparam int DW    = 18;
   localparam int CMP_W = (CNT_W > DW) ? CNT_W : DW;

   localparam logic [DW-1:0]    MIN_D    = DW'(MIN_DUTY);
   localparam logic [DW-1:0]    MAX_D    = DW'(MAX_DUTY);
   localparam logic [DW-1:0]    CENTER_D = DW'(CENTER_DUTY);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_CNT - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [DW-1:0]    shadow;
   logic [DW-1:0]    duty_active_q;
   logic             pwm_q;
   logic             tick_q;
   logic             clamped_q;

   logic [DW-1:0]    duty_in_clamped;
   logic             duty_out_of_range;
   logic [DW-1:0]    next_duty;

   always_comb begin
      duty_in_clamped   = bus.duty_in;
      duty_out_of_range = 1'b0;
      if (bus.duty_in < MIN_D) begin
         duty_in_clamped   = MIN_D;
         duty_out_of_range = 1'b1;
      end else if (bus.duty_in > MAX_D) begin
         duty_in_clamped   = MAX_D;
         duty_out_of_range = 1'b1;
      end
      // A strobe in the boundary cycle bypasses the shadow so it lands in the new period.
      next_duty = bus.duty_valid ? duty_in_clamped : shadow;
   end

   // NOTE: all state updates use non-blocking assignments so every register samples
   // pre-edge values; the asynchronous reset sits in the sensitivity list.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         shadow        <= CENTER_D;
         duty_active_q <= CENTER_D;
         pwm_q         <= 1'b0;
         tick_q        <= 1'b0;
         clamped_q     <= 1'b0;
      end else begin
         tick_q    <= 1'b0;
         clamped_q <= bus.duty_valid & duty_out_of_range;
         if (bus.duty_valid) begin
            shadow <= duty_in_clamped;
         end

         case (state)
            IDLE: begin
               cnt   <= '0;
               pwm_q <= 1'b0;
               if (bus.en) begin
                  duty_active_q <= next_duty;
                  state         <= RUN;
               end
            end
            RUN: begin
               pwm_q <= (CMP_W'(cnt) < CMP_W'(duty_active_q));
               if (cnt == LAST_CNT) begin
                  cnt    <= '0;
                  tick_q <= 1'b1;
                  if (bus.en) begin
                     duty_active_q <= next_duty;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.pwm_out      = pwm_q;
   assign bus.period_tick  = tick_q;
   assign bus.duty_active  = duty_active_q;
   assign bus.duty_clamped = clamped_q;

endmodule
